// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte assembler.
// The optional PID check is enabled by defining USB_RX_PID_CHECK_EN.
package usb_rx_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BIT_CNT_W     = 3;
    localparam int unsigned MAX_BYTES_DEF = 1027;
    localparam int unsigned CNT_W_DEF     = 11;

    // Seven zeros then a one, in arrival order, with new bits entering at the MSB
    localparam logic [BYTE_W-1:0] SYNC_PAT = 8'h80;

    localparam logic [BYTE_W-1:0] PID_TYPE_MASK  = 8'h0F;
    localparam logic [BYTE_W-1:0] PID_CHECK_MASK = 8'hF0;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        EOP    = 2'd2,
        WAIT_J = 2'd3
    } rx_state_e;

    // A PID is well formed when its upper nibble is the complement of its lower nibble
    function automatic logic pid_ok(input logic [BYTE_W-1:0] pid);
        logic [BYTE_W-1:0] type_bits;
        logic [BYTE_W-1:0] check_bits;
        type_bits  = pid & PID_TYPE_MASK;
        check_bits = ((~pid) & PID_CHECK_MASK) >> 4;
        return type_bits == check_bits;
    endfunction

endpackage

// File: rtl/usb_sync_detect.sv
// SYNC hunter: 8-bit arrival window compared against SYNC_PAT.
// Only non-stuffed bits are shifted, and only while the assembler is hunting.
module usb_sync_detect
    import usb_rx_pkg::*;
(
    input  logic gclk,
    input  logic reset_l,
    input  logic bit_en,
    input  logic halt_rx_shift,
    input  logic rx_din,
    input  logic hunt,
    output logic sync_hit_c
);

    logic [BYTE_W-1:0] window;
    logic [BYTE_W-1:0] window_next_c;
    logic              shift_c;

    assign shift_c       = bit_en & ~halt_rx_shift & hunt;
    assign window_next_c = {rx_din, window[BYTE_W-1:1]};

    // Hit is flagged on the same edge that shifts in the final SYNC bit
    assign sync_hit_c = shift_c & (window_next_c == SYNC_PAT);

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            window <= '0;
        end else if (shift_c) begin
            window <= window_next_c;
        end
    end

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// Receive byte assembler: SYNC hunt, LSB-first byte assembly, EOP framing and error flags.
// Define USB_RX_PID_CHECK_EN to flag a malformed PID on the first byte of each packet.
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_BYTES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              gclk,
    input  logic              reset_l,
    input  logic              bit_en,
    input  logic              rx_din,
    input  logic              halt_rx_shift,
    input  logic              se0,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_active,
    output logic              rx_error,
    output logic [CNT_W-1:0]  byte_cnt
);

    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(MAX_BYTES + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

    rx_state_e             state_q;
    rx_state_e             state_d;
    logic [BYTE_W-1:0]     shift_q;
    logic [BYTE_W-1:0]     shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d;
    logic [BYTE_W-1:0]     rx_data_d;
    logic                  rx_valid_d;
    logic                  rx_active_d;
    logic                  rx_error_d;
    logic [CNT_W-1:0]      byte_cnt_d;

    logic                  sync_hit_c;
    logic                  accept_c;
    logic                  stuff_bit_c;
    logic [BYTE_W-1:0]     byte_c;

    usb_sync_detect u_sync_detect (
        .gclk          (gclk),
        .reset_l       (reset_l),
        .bit_en        (bit_en),
        .halt_rx_shift (halt_rx_shift),
        .rx_din        (rx_din),
        .hunt          (state_q == HUNT),
        .sync_hit_c    (sync_hit_c)
    );

    assign accept_c    = bit_en & ~halt_rx_shift;
    assign stuff_bit_c = bit_en & halt_rx_shift;
    assign byte_c      = {rx_din, shift_q[BYTE_W-1:1]};

    // State and output registers
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= HUNT;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_active <= 1'b0;
            rx_error  <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            rx_active <= rx_active_d;
            rx_error  <= rx_error_d;
            byte_cnt  <= byte_cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        rx_active_d = rx_active;
        rx_error_d  = rx_error;
        byte_cnt_d  = byte_cnt;

        unique case (state_q)
            HUNT: begin
                if (sync_hit_c) begin
                    state_d     = DATA;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    rx_active_d = 1'b1;
                    rx_error_d  = 1'b0;
                    byte_cnt_d  = '0;
                end
            end

            DATA: begin
                if (stuff_bit_c) begin
                    // A stuffed bit must be a zero; a one here is a stuff error
                    if (rx_din) begin
                        rx_error_d = 1'b1;
                    end
                end else if (accept_c) begin
                    if (se0) begin
                        state_d   = EOP;
                        bit_cnt_d = '0;
                        if (bit_cnt_q != '0) begin
                            rx_error_d = 1'b1;
                        end
                    end else begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d  = byte_c;
                            rx_valid_d = 1'b1;
                            if (byte_cnt != CNT_SAT) begin
                                byte_cnt_d = byte_cnt + CNT_W'(1);
                            end
                            if (byte_cnt >= CNT_MAX) begin
                                rx_error_d = 1'b1;
                            end
`ifdef USB_RX_PID_CHECK_EN
                            if ((byte_cnt == '0) && !pid_ok(byte_c)) begin
                                rx_error_d = 1'b1;
                            end
`endif
                        end
                    end
                end
            end

            EOP: begin
                if (accept_c) begin
                    state_d = WAIT_J;
                    if (!se0) begin
                        rx_error_d = 1'b1;
                    end
                end
            end

            WAIT_J: begin
                if (accept_c && !se0) begin
                    state_d     = HUNT;
                    rx_active_d = 1'b0;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Self-checking bench for usb_rx_byte_assembler: packet vector table, scoreboard on rx_valid,
// plus hand-written length-overflow, mid-packet reset and (optional) PID sequences.
module tb_usb_rx_byte_assembler;

    localparam int unsigned MAX_BYTES = 1027;
    localparam int unsigned CNT_W     = 11;

    logic             gclk;
    logic             reset_l;
    logic             bit_en;
    logic             rx_din;
    logic             halt_rx_shift;
    logic             se0;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_active;
    logic             rx_error;
    logic [CNT_W-1:0] byte_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb[$];

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         halt_at;
        logic       halt_din;
        int         tail_bits;
        logic [7:0] tail_val;
        int         n_se0;
        int         n_j;
        logic       exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[6];

    usb_rx_byte_assembler #(
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .gclk          (gclk),
        .reset_l       (reset_l),
        .bit_en        (bit_en),
        .rx_din        (rx_din),
        .halt_rx_shift (halt_rx_shift),
        .se0           (se0),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_active     (rx_active),
        .rx_error      (rx_error),
        .byte_cnt      (byte_cnt)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest expected byte
    always @(negedge gclk) begin
        if (reset_l && rx_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got byte %0h with no byte expected", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic din, input logic halt, input logic s0);
        @(negedge gclk);
        bit_en        = 1'b1;
        rx_din        = din;
        halt_rx_shift = halt;
        se0           = s0;
        @(posedge gclk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge gclk);
        bit_en        = 1'b0;
        rx_din        = 1'b0;
        halt_rx_shift = 1'b0;
        se0           = 1'b0;
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) send_bit(b[k], 1'b0, 1'b0);
    endtask

    task automatic send_eop();
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] bits;
        bits = {v.b1, v.b0};
        send_sync();
        check("active_after_sync", 32'(rx_active), 32'd1);
        for (int i = 0; i < v.nbytes * 8; i++) begin
            if (i % 8 == 0) sb.push_back(i == 0 ? v.b0 : v.b1);
            if (i == v.halt_at) send_bit(v.halt_din, 1'b1, 1'b0);
            send_bit(bits[i], 1'b0, 1'b0);
        end
        for (int t = 0; t < v.tail_bits; t++) send_bit(v.tail_val[t], 1'b0, 1'b0);
        for (int s = 0; s < v.n_se0; s++) send_bit(1'b0, 1'b0, 1'b1);
        check("active_before_j", 32'(rx_active), 32'd1);
        for (int j = 0; j < v.n_j; j++) send_bit(1'b1, 1'b0, 1'b0);
        check("active_after_j", 32'(rx_active), 32'd0);
        idle(3);
        check("rx_error_end", 32'(rx_error), 32'(v.exp_err));
        check("byte_cnt_end", 32'(byte_cnt), 32'(v.exp_cnt));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{2, 8'hA5, 8'h3C, -1, 1'b0, 0, 8'h00, 2, 1, 1'b0, 2};
        vecs[1] = '{2, 8'hA5, 8'h3C,  4, 1'b0, 0, 8'h00, 2, 1, 1'b0, 2};
        vecs[2] = '{2, 8'hA5, 8'h3C, 11, 1'b1, 0, 8'h00, 2, 1, 1'b1, 2};
        vecs[3] = '{1, 8'hC3, 8'h00, -1, 1'b0, 5, 8'h15, 2, 1, 1'b1, 1};
        vecs[4] = '{2, 8'h69, 8'h96, -1, 1'b0, 0, 8'h00, 2, 1, 1'b0, 2};
        vecs[5] = '{2, 8'h3C, 8'hA5, -1, 1'b0, 0, 8'h00, 1, 2, 1'b1, 2};

        reset_l       = 1'b0;
        bit_en        = 1'b0;
        rx_din        = 1'b0;
        halt_rx_shift = 1'b0;
        se0           = 1'b0;
        repeat (3) @(posedge gclk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_active", 32'(rx_active), 32'd0);
        check("reset_rx_error", 32'(rx_error), 32'd0);
        check("reset_byte_cnt", 32'(byte_cnt), 32'd0);
        @(negedge gclk);
        reset_l = 1'b1;
        idle(2);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Length overflow: error on byte MAX_BYTES+1, counter saturates, bytes keep flowing
        send_sync();
        for (int i = 1; i <= MAX_BYTES + 2; i++) begin
            sb.push_back(8'h00);
            send_byte(8'h00);
            if (i == MAX_BYTES) begin
                check("len_err_at_max", 32'(rx_error), 32'd0);
                check("len_cnt_at_max", 32'(byte_cnt), 32'(MAX_BYTES));
            end else if (i == MAX_BYTES + 1) begin
                check("len_err_over", 32'(rx_error), 32'd1);
                check("len_cnt_over", 32'(byte_cnt), 32'(MAX_BYTES + 1));
            end
        end
        check("len_cnt_sat", 32'(byte_cnt), 32'(MAX_BYTES + 1));
        send_eop();
        check("len_sb_drained", 32'(sb.size()), 32'd0);

        // Mid-packet asynchronous reset
        send_sync();
        sb.push_back(8'h5A);
        send_byte(8'h5A);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check("pre_reset_error", 32'(rx_error), 32'd1);
        check("pre_reset_cnt", 32'(byte_cnt), 32'd1);
        @(negedge gclk);
        bit_en  = 1'b0;
        reset_l = 1'b0;
        #1;
        check("async_rx_data", 32'(rx_data), 32'd0);
        check("async_rx_active", 32'(rx_active), 32'd0);
        check("async_rx_error", 32'(rx_error), 32'd0);
        check("async_byte_cnt", 32'(byte_cnt), 32'd0);
        check("async_rx_valid", 32'(rx_valid), 32'd0);
        @(negedge gclk);
        reset_l = 1'b1;
        idle(2);
        send_sync();
        sb.push_back(8'hD2);
        send_byte(8'hD2);
        send_eop();
        check("post_reset_error", 32'(rx_error), 32'd0);
        check("post_reset_cnt", 32'(byte_cnt), 32'd1);
        check("post_reset_data", 32'(rx_data), 32'hD2);
        check("post_reset_sb", 32'(sb.size()), 32'd0);

`ifdef USB_RX_PID_CHECK_EN
        send_sync();
        sb.push_back(8'h69);
        send_byte(8'h69);
        check("pid_good_valid", 32'(rx_valid), 32'd1);
        check("pid_good_error", 32'(rx_error), 32'd0);
        send_eop();
        send_sync();
        sb.push_back(8'h66);
        send_byte(8'h66);
        check("pid_bad_valid", 32'(rx_valid), 32'd1);
        check("pid_bad_error", 32'(rx_error), 32'd1);
        send_eop();
        check("pid_sb_drained", 32'(sb.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_byte_assembler.md
Name: usb_rx_byte_assembler

Overview:
- Receive-path stage directly downstream of the bit unstuffer.
- Consumes the serial unstuffed bit stream plus its stuffed-bit halt strobe, hunts for SYNC, and assembles LSB-first bytes.
- Drives byte-valid pulses to the packet decoder, frames each packet with rx_active, and flags stuff, alignment and length errors at EOP.

Parameters:
- MAX_BYTES, 1027: maximum bytes per packet after SYNC (PID + 1024 data + CRC16); exceeding it is an error.
- CNT_W, 11: width of the byte counter; must satisfy 2**CNT_W > MAX_BYTES.

Ports:
- gclk  input  1  global 12 MHz clock.
- reset_l  input  1  asynchronous active-low reset.
- bit_en  input  1  qualifies rx_din/halt_rx_shift/se0 for one bit time.
- rx_din  input  1  unstuffed serial data bit, LSB of each byte first.
- halt_rx_shift  input  1  current rx_din is a stuffed bit; discard it.
- se0  input  1  line in SE0 state (EOP signalling).
- rx_data  output  8  assembled byte; held until the next byte completes.
- rx_valid  output  1  one-gclk pulse when rx_data is updated.
- rx_active  output  1  high from SYNC detection through EOP completion.
- rx_error  output  1  sticky per packet; cleared at the next SYNC.
- byte_cnt  output  CNT_W  bytes received in the current packet, saturating at MAX_BYTES+1.

Behaviour:
- Clock and reset: one clock, gclk. Reset is asynchronous, active-low, on reset_l.
- Reset values: rx_data=8'h00, rx_valid=0, rx_active=0, rx_error=0, byte_cnt=0, state=HUNT, shift and bit counter=0.
- Bit acceptance: all state updates occur only on gclk edges with bit_en=1.
  - A bit with halt_rx_shift=1 is never shifted or counted.
  - In DATA, a halt bit with rx_din=1 sets rx_error (stuff error).
- HUNT:
  - Shift rx_din into an 8-bit window (new bit at MSB).
  - When the window equals SYNC_PAT=8'h80 (seven 0s then a 1, arrival order), go to DATA.
  - On that transition: rx_active=1, byte_cnt=0, bit_cnt=0, rx_error=0.
  - se0 is ignored in HUNT.
- DATA:
  - Each accepted non-SE0 bit shifts into the byte register at MSB; bit_cnt increments modulo 8.
  - On the 8th bit, the same edge loads rx_data, pulses rx_valid for exactly one gclk, and increments byte_cnt (saturating).
  - Byte latency is 1 gclk after the 8th bit's bit_en edge.
  - If byte_cnt would exceed MAX_BYTES, set rx_error. Bytes are still delivered until EOP.
  - se0=1 on an accepted bit moves to EOP. That bit is not shifted.
  - If bit_cnt!=0 at that point, set rx_error (alignment error) and discard the partial byte.
- EOP:
  - Requires se0=1 on the next accepted bit; then go to WAIT_J.
  - If se0=0 on that bit, set rx_error and go to WAIT_J.
- WAIT_J:
  - First accepted bit with se0=0 moves to HUNT and drops rx_active on that edge.
  - rx_error holds its value until the next SYNC.
- Simultaneous events: halt_rx_shift takes priority over se0. A halted bit never enters the EOP path.
- Mid-packet reset: all outputs return to reset values immediately, asynchronously. No rx_valid is emitted for the partial byte.
- byte_cnt wraps nowhere. It saturates at MAX_BYTES+1.

Optional Feature:
- Macro: USB_RX_PID_CHECK_EN.
- With the macro defined: on the first byte of a packet, if rx_data[3:0] != ~rx_data[7:4], set rx_error in the same cycle as the rx_valid pulse.
- Without the macro: no PID check; the first byte is treated like any other.

Decomposition:
- Package usb_rx_pkg holds:
  - state encoding HUNT/DATA/EOP/WAIT_J (2-bit);
  - SYNC_PAT=8'h80;
  - default MAX_BYTES;
  - PID nibble mask constants.
- Natural sub-module: usb_sync_detect, containing the 8-bit window and the SYNC_PAT compare, gated by bit_en and halt_rx_shift.
- Byte assembly and the FSM stay in the top module.

Test Plan:
- bit_en every cycle; send 00000001, then bytes 8'hA5 and 8'h3C LSB-first, then two SE0 bits and one J bit.
  - Two rx_valid pulses with rx_data A5 then 3C.
  - byte_cnt=2; rx_error=0.
  - rx_active high from SYNC through the J bit.
- Same packet with one extra halt_rx_shift=1, rx_din=0 bit inserted mid-byte.
  - Identical bytes; no error.
- Same packet, but the halt bit carries rx_din=1.
  - rx_error=1 at EOP; bytes still delivered.
- SYNC, 8'hC3, then 5 bits, then SE0.
  - One rx_valid (C3); no sixth-bit byte.
  - rx_error=1 (alignment error).
- SYNC, then MAX_BYTES+1 bytes of 8'h00.
  - rx_error set on byte MAX_BYTES+1; byte_cnt saturates at 1028.
- With USB_RX_PID_CHECK_EN, first byte 8'h69 gives no error; first byte 8'h66 gives rx_error=1 coincident with rx_valid.
- Assert reset_l low mid-byte: outputs return to 0 immediately; the next SYNC restarts cleanly.
